// File: rtl/multdiv_sequencer.sv
// Iterative signed multiply/divide unit for the execute stage.
// A mult (aluop 00110) or div (aluop 00111) is accepted on `start` from IDLE or DONE.
// It runs one bit per clock (shift-add multiply, restoring divide on magnitudes),
// then pulses multDivReady for one cycle with the result and writeback fields.
// Optional build macro: MULTDIV_EARLY_OUT_EN. When it is defined, a multiply stops
// as soon as the remaining multiplier bits are all zero, and |B|==0 finishes at once.
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-low reset
//   start, DX_IR       issue pulse and the D/X instruction
//   operandA/operandB  bypassed rs/rt values, sampled only at the accepting edge
//   multDivReady       one-cycle result-valid pulse
//   busy               high in RUN and DONE
//   PW_IR              latched copy of the issuing instruction
//   result, exception  low WIDTH bits of the result, overflow/div-by-zero flag
//   wb_rd, wb_data     writeback destination and data (status code on exception)
module multdiv_sequencer #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned RSTATUS_REG   = 30,
    parameter int unsigned MULT_EXC_CODE = 4,
    parameter int unsigned DIV_EXC_CODE  = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      DX_IR,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             multDivReady,
    output logic             busy,
    output logic [31:0]      PW_IR,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic [4:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned W2 = 2 * WIDTH;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [4:0] OPC_ALU  = 5'b00000;
    localparam logic [4:0] ALU_MULT = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    logic [1:0]       state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    // Multiply: acc = partial product, sh_a = shifted multiplicand, sh_b = multiplier.
    // Divide:   acc[WIDTH-1:0] = remainder, sh_a[WIDTH-1:0] = dividend/quotient, sh_b = divisor.
    logic [W2-1:0]    acc, acc_n, sh_a, sh_a_n;
    logic [WIDTH-1:0] sh_b, sh_b_n;
    logic             sign, sign_n, is_div, is_div_n;
    logic [31:0]      pw_ir_n;
    logic [WIDTH-1:0] result_n, wb_data_n;
    logic             exc_n, ready_n, busy_n;
    logic [4:0]       wb_rd_n;

    logic             valid_start_c, last_c, qbit_c, zero_mult_c;
    logic [WIDTH-1:0] abs_a_c, abs_b_c, quot_c, squot_c, rem_next_c;
    logic [W2-1:0]    prod_c, sprod_c;
    logic [WIDTH:0]   rem_sh_c, divisor_c;

    // Instruction decode and operand magnitudes
    assign valid_start_c = start && (DX_IR[31:27] == OPC_ALU) &&
                           ((DX_IR[6:2] == ALU_MULT) || (DX_IR[6:2] == ALU_DIV));
    assign abs_a_c = operandA[WIDTH-1] ? ((~operandA) + WIDTH'(1)) : operandA;
    assign abs_b_c = operandB[WIDTH-1] ? ((~operandB) + WIDTH'(1)) : operandB;

    // Shift-add step and signed product
    assign prod_c  = acc + (sh_b[0] ? sh_a : W2'(0));
    assign sprod_c = sign ? ((~prod_c) + W2'(1)) : prod_c;

    // Restoring divide step: the new remainder always fits WIDTH bits since it is below the divisor
    assign rem_sh_c   = {acc[WIDTH-1:0], sh_a[WIDTH-1]};
    assign divisor_c  = {1'b0, sh_b};
    assign qbit_c     = (rem_sh_c >= divisor_c);
    assign rem_next_c = qbit_c ? WIDTH'(rem_sh_c - divisor_c) : WIDTH'(rem_sh_c);
    assign quot_c     = {sh_a[WIDTH-2:0], qbit_c};
    assign squot_c    = sign ? ((~quot_c) + WIDTH'(1)) : quot_c;

`ifdef MULTDIV_EARLY_OUT_EN
    assign last_c      = (cnt == CW'(WIDTH - 1)) || (!is_div && (sh_b[WIDTH-1:1] == '0));
    assign zero_mult_c = (DX_IR[6:2] == ALU_MULT) && (abs_b_c == '0);
`else
    assign last_c      = (cnt == CW'(WIDTH - 1));
    assign zero_mult_c = 1'b0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        acc_n    = acc;
        sh_a_n   = sh_a;
        sh_b_n   = sh_b;
        sign_n   = sign;
        is_div_n = is_div;
        pw_ir_n  = PW_IR;
        result_n = result;
        exc_n    = exception;
        ready_n  = 1'b0;

        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (valid_start_c) begin
                    state_n  = RUN;
                    cnt_n    = '0;
                    acc_n    = '0;
                    pw_ir_n  = DX_IR;
                    is_div_n = (DX_IR[6:2] == ALU_DIV);
                    sign_n   = operandA[WIDTH-1] ^ operandB[WIDTH-1];
                    sh_a_n   = W2'(abs_a_c);
                    sh_b_n   = abs_b_c;
                    result_n = '0;
                    exc_n    = 1'b0;
                    // Divide-by-zero (and zero multiplier with early-out) finish without iterating
                    if (is_div_n && (abs_b_c == '0)) begin
                        state_n = DONE;
                        exc_n   = 1'b1;
                        ready_n = 1'b1;
                    end else if (zero_mult_c) begin
                        state_n = DONE;
                        ready_n = 1'b1;
                    end
                end
            end
            RUN: begin
                cnt_n = cnt + CW'(1);
                if (!is_div) begin
                    acc_n  = prod_c;
                    sh_a_n = sh_a << 1;
                    sh_b_n = sh_b >> 1;
                    if (last_c) begin
                        result_n = sprod_c[WIDTH-1:0];
                        // Representable only if the upper WIDTH+1 bits are a pure sign extension
                        exc_n    = !((&sprod_c[W2-1:WIDTH-1]) || (~|sprod_c[W2-1:WIDTH-1]));
                    end
                end else begin
                    acc_n  = W2'(rem_next_c);
                    sh_a_n = W2'(quot_c);
                    if (last_c) begin
                        result_n = squot_c;
                        exc_n    = 1'b0;
                    end
                end
                if (last_c) begin
                    state_n = DONE;
                    cnt_n   = '0;
                    ready_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n    = (state_n != IDLE);
        wb_rd_n   = exc_n ? 5'(RSTATUS_REG) : pw_ir_n[26:22];
        wb_data_n = exc_n ? (is_div_n ? WIDTH'(DIV_EXC_CODE) : WIDTH'(MULT_EXC_CODE)) : result_n;
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            acc          <= '0;
            sh_a         <= '0;
            sh_b         <= '0;
            sign         <= 1'b0;
            is_div       <= 1'b0;
            PW_IR        <= '0;
            result       <= '0;
            exception    <= 1'b0;
            multDivReady <= 1'b0;
            busy         <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            acc          <= acc_n;
            sh_a         <= sh_a_n;
            sh_b         <= sh_b_n;
            sign         <= sign_n;
            is_div       <= is_div_n;
            PW_IR        <= pw_ir_n;
            result       <= result_n;
            exception    <= exc_n;
            multDivReady <= ready_n;
            busy         <= busy_n;
            wb_rd        <= wb_rd_n;
            wb_data      <= wb_data_n;
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench for multdiv_sequencer: expected results come from a native-arithmetic
// model when an operation is launched and are compared when multDivReady pulses.
module tb_multdiv_sequencer;

    localparam logic [4:0] MULT = 5'b00110;
    localparam logic [4:0] DIV  = 5'b00111;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] DX_IR = '0;
    logic [31:0] operandA = '0;
    logic [31:0] operandB = '0;
    logic        multDivReady, busy, exception;
    logic [31:0] PW_IR, result, wb_data;
    logic [4:0]  wb_rd;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        logic [4:0]  rd;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t sb[$];

    multdiv_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .DX_IR(DX_IR),
        .operandA(operandA), .operandB(operandB), .multDivReady(multDivReady),
        .busy(busy), .PW_IR(PW_IR), .result(result), .exception(exception),
        .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk_ir(input logic [4:0] aluop, input logic [4:0] rd);
        return {5'b00000, rd, 15'd0, aluop, 2'b00};
    endfunction

    // Reference model; lat = edges after the accepting edge until multDivReady is seen
    function automatic exp_t model(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      p;
        logic [63:0] pv;
        logic [31:0] mb;
        bit          dv;
        dv    = (ir[6:2] == DIV);
        e.lat = 32;
        mb    = 32'd0;
        if (!dv) begin
            p     = longint'($signed(a)) * longint'($signed(b));
            pv    = p;
            e.res = pv[31:0];
            e.exc = !((pv[63:31] == 33'd0) || (pv[63:31] == {33{1'b1}}));
`ifdef MULTDIV_EARLY_OUT_EN
            mb    = b[31] ? (32'd0 - b) : b;
            e.lat = 0;
            for (int i = 0; i < 32; i++) if (mb[i]) e.lat = i + 1;
`endif
        end else if (b == 32'd0) begin
            e.res = 32'd0;
            e.exc = 1'b1;
            e.lat = 0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000;
            e.exc = 1'b0;
        end else begin
            e.res = $signed(a) / $signed(b);
            e.exc = 1'b0;
        end
        e.rd   = e.exc ? 5'd30 : ir[26:22];
        e.data = e.exc ? (dv ? 32'd5 : 32'd4) : e.res;
        return e;
    endfunction

    // Drive one start pulse across an edge, then scramble inputs to prove they are not re-sampled
    task automatic launch(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b);
        sb.push_back(model(ir, a, b));
        start = 1'b1; DX_IR = ir; operandA = a; operandB = b;
        @(posedge clock); #1;
        start = 1'b0; DX_IR = $urandom; operandA = $urandom; operandB = $urandom;
    endtask

    task automatic wait_ready(output int lat, output bit to);
        lat = 0;
        while (!multDivReady && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        to = !multDivReady;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (multDivReady !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", multDivReady); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (result !== 32'd0 || exception !== 1'b0) begin errors++; $display("FAIL reset_result got %h/%b want 0/0", result, exception); end
        checks++; if (PW_IR !== 32'd0 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb got ir=%h rd=%0d data=%h want zeros", PW_IR, wb_rd, wb_data); end
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        // Starts with an unsupported aluop or a non-ALU opcode are ignored
        start = 1'b1; DX_IR = mk_ir(5'b00000, 5'd3); operandA = 32'd1; operandB = 32'd1;
        @(posedge clock); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL decode_add busy got %b want 0", busy); end
        DX_IR = mk_ir(MULT, 5'd3) | 32'h0800_0000;
        @(posedge clock); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b0 || multDivReady !== 1'b0) begin errors++; $display("FAIL decode_opcode busy/ready got %b/%b want 0/0", busy, multDivReady); end
    endtask

    task automatic test_ops();
        logic [31:0] ta[$];
        logic [31:0] tb[$];
        logic [4:0]  top[$];
        exp_t        e;
        int          lat;
        bit          to;
        ta  = '{32'd7, 32'h0001_0000, 32'hFFFF_FF9C, 32'h8000_0000, 32'd5, 32'h7FFF_FFFF,
                32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'd17, 32'd0};
        tb  = '{32'hFFFF_FFFA, 32'h0001_0000, 32'd7, 32'hFFFF_FFFF, 32'd3, 32'h7FFF_FFFF,
                32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'd5};
        top = '{MULT, MULT, DIV, DIV, MULT, MULT, MULT, MULT, MULT, DIV, MULT};
        for (int r = 0; r < 6; r++) begin
            ta.push_back($urandom);
            tb.push_back(($urandom_range(0, 1) == 1) ? (32'd0 - 32'($urandom_range(1, 4095))) : $urandom);
            top.push_back((r % 2 == 0) ? MULT : DIV);
        end
        for (int i = 0; i < ta.size(); i++) begin
            launch(mk_ir(top[i], 5'(i + 1)), ta[i], tb[i]);
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL op%0d busy_after_start got %b want 1", i, busy); end
            wait_ready(lat, to);
            e = sb.pop_front();
            checks++;
            if (to) begin
                errors++; $display("FAIL op%0d timeout: no multDivReady within 100 cycles", i);
            end else begin
                checks++; if (lat !== e.lat) begin errors++; $display("FAIL op%0d latency got %0d want %0d", i, lat, e.lat); end
                checks++; if (result !== e.res) begin errors++; $display("FAIL op%0d result got %h want %h", i, result, e.res); end
                checks++; if (exception !== e.exc) begin errors++; $display("FAIL op%0d exception got %b want %b", i, exception, e.exc); end
                checks++; if (wb_rd !== e.rd || wb_data !== e.data) begin errors++; $display("FAIL op%0d wb got rd=%0d data=%h want rd=%0d data=%h", i, wb_rd, wb_data, e.rd, e.data); end
                checks++; if (PW_IR !== mk_ir(top[i], 5'(i + 1))) begin errors++; $display("FAIL op%0d pw_ir got %h want %h", i, PW_IR, mk_ir(top[i], 5'(i + 1))); end
                @(posedge clock); #1;
                checks++; if (multDivReady !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL op%0d after_done ready/busy got %b/%b want 0/0", i, multDivReady, busy); end
                checks++; if (result !== e.res || wb_data !== e.data) begin errors++; $display("FAIL op%0d hold got %h/%h want %h/%h", i, result, wb_data, e.res, e.data); end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        bit   to;
        launch(mk_ir(DIV, 5'd11), 32'd9, 32'd0);
        wait_ready(lat, to);
        e = sb.pop_front();
        checks++;
        if (to) begin
            errors++; $display("FAIL div0 timeout: no multDivReady within 100 cycles");
        end else begin
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL div0 latency got %0d want %0d", lat, e.lat); end
            checks++; if (exception !== 1'b1 || result !== 32'd0) begin errors++; $display("FAIL div0 exc/result got %b/%h want 1/0", exception, result); end
            checks++; if (wb_rd !== e.rd || wb_data !== e.data) begin errors++; $display("FAIL div0 wb got rd=%0d data=%h want rd=%0d data=%h", wb_rd, wb_data, e.rd, e.data); end
        end
        // Issue from the DONE cycle, then poke a stray start while running
        launch(mk_ir(MULT, 5'd12), 32'd12345, 32'h0012_3456);
        checks++; if (busy !== 1'b1 || multDivReady !== 1'b0) begin errors++; $display("FAIL b2b accept busy/ready got %b/%b want 1/0", busy, multDivReady); end
        repeat (4) begin @(posedge clock); #1; end
        start = 1'b1; DX_IR = mk_ir(DIV, 5'd13); operandA = 32'd1; operandB = 32'd0;
        @(posedge clock); #1;
        start = 1'b0;
        wait_ready(lat, to);
        lat += 5;
        e = sb.pop_front();
        checks++;
        if (to) begin
            errors++; $display("FAIL b2b timeout: no multDivReady within 100 cycles");
        end else begin
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL b2b latency got %0d want %0d", lat, e.lat); end
            checks++; if (result !== e.res || exception !== e.exc) begin errors++; $display("FAIL b2b result got %h/%b want %h/%b", result, exception, e.res, e.exc); end
            checks++; if (wb_rd !== e.rd || wb_data !== e.data) begin errors++; $display("FAIL b2b wb got rd=%0d data=%h want rd=%0d data=%h", wb_rd, wb_data, e.rd, e.data); end
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int   lat;
        int   pulses;
        bit   to;
        launch(mk_ir(MULT, 5'd14), 32'd1000, 32'hFFFE_EE90);
        void'(sb.pop_front());
        repeat (9) begin @(posedge clock); #1; end
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || multDivReady !== 1'b0) begin errors++; $display("FAIL abort busy/ready got %b/%b want 0/0", busy, multDivReady); end
        checks++; if (result !== 32'd0 || exception !== 1'b0 || PW_IR !== 32'd0 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin errors++; $display("FAIL abort outputs got %h %b %h %0d %h want zeros", result, exception, PW_IR, wb_rd, wb_data); end
        pulses = 0;
        repeat (3) begin @(posedge clock); #1; if (multDivReady) pulses++; end
        @(negedge clock); reset = 1'b1;
        repeat (40) begin @(posedge clock); #1; if (multDivReady) pulses++; end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort ready_pulses got %0d want 0", pulses); end
        launch(mk_ir(MULT, 5'd15), 32'd3, 32'd3);
        wait_ready(lat, to);
        e = sb.pop_front();
        checks++;
        if (to) begin
            errors++; $display("FAIL post_reset timeout: no multDivReady within 100 cycles");
        end else begin
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL post_reset latency got %0d want %0d", lat, e.lat); end
            checks++; if (result !== 32'd9 || wb_data !== 32'd9 || wb_rd !== 5'd15) begin errors++; $display("FAIL post_reset result got %h/%h rd=%0d want 9/9 rd=15", result, wb_data, wb_rd); end
        end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Iterative signed multiply/divide unit in the execute stage. It runs alongside the ALU and is launched when a mult or div instruction sits in D/X.
- It holds its own copy of the instruction (PW_IR) and operands while it computes.
- It feeds the pipeline stall controller through `multDivReady`, `busy` and PW_IR[26:22].
- It feeds the writeback mux through `wb_rd`, `wb_data` and `exception`.

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.
- RSTATUS_REG, 30, destination register for exception status writes.
- MULT_EXC_CODE, 4, value written to RSTATUS_REG on multiply overflow.
- DIV_EXC_CODE, 5, value written to RSTATUS_REG on divide-by-zero.

Ports:
- clock  in  1  sole clock; rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle pulse: the mult/div in DX_IR is newly entering X.
- DX_IR  in  32  D/X instruction; opcode [31:27], rd [26:22], aluop [6:2].
- operandA  in  WIDTH  bypassed rs value.
- operandB  in  WIDTH  bypassed rt value.
- multDivReady  out  1  result valid; one-cycle pulse.
- busy  out  1  operation in flight (RUN or DONE).
- PW_IR  out  32  latched copy of the issuing instruction.
- result  out  WIDTH  product/quotient (low WIDTH bits).
- exception  out  1  overflow or divide-by-zero for the current result.
- wb_rd  out  5  exception ? RSTATUS_REG : PW_IR[26:22].
- wb_data  out  WIDTH  exception ? MULT_EXC_CODE/DIV_EXC_CODE (zero-extended) : result.

Behaviour:
- Decode: op is valid when DX_IR[31:27]==00000 and aluop is 00110 (mult) or 00111 (div). `start` with any other aluop is ignored.
- States: IDLE, RUN, DONE. The iteration counter is 5 bits for WIDTH=32.
- Reset (async, reset==0): state IDLE, counter 0, all outputs and internal registers 0. Reset mid-operation aborts the operation with no ready pulse.
- IDLE + valid start at edge E0:
  - Latch PW_IR<=DX_IR.
  - Latch |operandA| and |operandB|; record sign = A[31]^B[31] and op type.
  - Clear the accumulator; go to RUN, counter 0.
- Div with operandB==0 at E0: go directly to DONE with result=0 and exception=1. multDivReady is visible in the cycle after E0.
- RUN, multiply:
  - Unsigned shift-add, one multiplier bit per edge, LSB first, into a 2*WIDTH accumulator.
  - After WIDTH iterations, apply the sign to produce the 64-bit signed product.
  - result = low WIDTH bits.
  - exception=1 iff the product is not representable in WIDTH signed bits (upper WIDTH+1 bits not all equal).
- RUN, divide:
  - Restoring division on magnitudes, one quotient bit per edge, MSB first.
  - Quotient is negated if sign=1; remainder is discarded.
  - MIN_INT / -1 yields 0x80000000 with exception=0 (wraps).
- RUN completes: the iteration at counter==WIDTH-1 moves the state to DONE. With the default build, multDivReady is high exactly in the cycle after edge E32 (32 cycles after the start edge).
- DONE:
  - multDivReady=1 for one cycle; result, exception, wb_rd, wb_data are valid.
  - Next edge: return to IDLE, or to RUN if a valid start is present (back-to-back issue is accepted from DONE).
- result, exception, PW_IR and wb_* hold their values after DONE until the next accepted start. Only multDivReady pulses.
- busy=1 in RUN and DONE, 0 in IDLE.
- start in RUN is ignored; the stall controller prevents it, but it must not corrupt state.
- Operands are sampled only at the accepting edge; later changes on operandA/B/DX_IR have no effect.

Optional Feature:
- Macro: MULTDIV_EARLY_OUT_EN.
- Defined: multiply terminates early once the remaining unshifted multiplier bits are all zero.
  - If the highest set bit of |B| is at index k, multiply takes k+1 iterations.
  - |B|==0 goes from IDLE straight to DONE, like divide-by-zero.
  - Division is unaffected.
- Undefined: every multiply takes exactly WIDTH iterations.

Test Plan:
1. mult 7 * -6 (aluop 00110, rd=5) -> multDivReady pulses 32 cycles after start; result=0xFFFFFFD6, exception=0, wb_rd=5, wb_data=0xFFFFFFD6; busy=0 one cycle later.
2. mult 0x00010000 * 0x00010000 -> exception=1, wb_rd=30, wb_data=4, result=0x00000000.
3. div -100 / 7 -> quotient 0xFFFFFFF2 (-14) after 32 cycles; div 0x80000000 / -1 -> 0x80000000, exception=0.
4. div 9 / 0 -> multDivReady 1 cycle after start; exception=1, wb_rd=30, wb_data=5. Then a start in the DONE cycle is accepted and completes normally.
5. Reset driven low at iteration 10 of a mult -> outputs 0 immediately, no ready pulse. After reset is released, a new mult 3*3 gives result 9.
6. Early-out: mult 5 * 3 with MULTDIV_EARLY_OUT_EN -> ready 2 cycles after start, result 15. Without the macro -> ready 32 cycles after start, result 15.
